// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : simon_pkg
//  Description : Shared types and helpers for the playback controller:
//                FSM state enum, address/code widths and the code-to-LED
//                one-hot decode.
//  Revision    : 1.0  initial release
// ============================================================================
package simon_pkg;

  localparam int ADDR_W = 4;
  localparam int CODE_W = 2;
  localparam int LED_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ON    = 3'd3,
    ST_OFF   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Code 0 lights bit 0, code 3 lights bit 3.
  function automatic logic [LED_W-1:0] led_decode(input logic [CODE_W-1:0] code);
    return {{(LED_W-1){1'b0}}, 1'b1} << code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/playback_controller_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Down-counting tick timer for the ON/OFF phases. The phase
//                length is loaded, each enabled tick decrements, and tc_o
//                flags the enabled tick that completes the phase.
//  Ports       : clk, rst_n (async active-low)
//                clr_i      - force count to zero (highest priority)
//                load_i     - load load_val_i as the phase length
//                load_val_i - phase length in ticks
//                en_i       - a countable tick this cycle
//                tc_o       - terminal count: this tick ends the phase
//  Revision    : 1.0  initial release
// ============================================================================
module phase_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Remaining count of one means the tick now being seen is the last one.
  assign tc_o = en_i && (count_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/playback_controller.sv
`default_nettype none
// ============================================================================
//  Module      : playback_controller
//  Description : Plays the first round_len entries of the sequence ROM on
//                one-hot LEDs: each step is lit for ON_TICKS ticks followed
//                by an OFF_TICKS dark gap. The ROM read port is shared with
//                the input checker and owned by this block while busy.
//  Ports       : clk, reset (async active-low), tick, start, round_len,
//                rom_rd_data, chk_rd_addr -> rom_rd_addr, led, busy, done,
//                len_err; abort (only when PLAYBACK_ABORT_EN is defined).
//  Build macro : PLAYBACK_ABORT_EN - adds the abort input.
//  Revision    : 1.0  initial release
// ============================================================================
module playback_controller
  import simon_pkg::*;
#(
  parameter int N         = 10,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic [ADDR_W-1:0] round_len,
`ifdef PLAYBACK_ABORT_EN
  input  logic              abort,
`endif
  input  logic [CODE_W-1:0] rom_rd_data,
  input  logic [ADDR_W-1:0] chk_rd_addr,
  output logic [ADDR_W-1:0] rom_rd_addr,
  output logic [LED_W-1:0]  led,
  output logic              busy,
  output logic              done,
  output logic              len_err
);

  localparam int TMAX  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CNT_W = $clog2(TMAX + 1);
  localparam logic [ADDR_W-1:0] N_L = ADDR_W'(N);

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] len_q;
  logic [CODE_W-1:0] code_q;
  logic              busy_q;
  logic              done_q;
  logic              len_err_q;

  logic              w_abort;
  logic              w_len_ok;
  logic              w_last;
  logic              w_tc;
  logic              w_cnt_en;
  logic              w_tmr_clr;
  logic              w_tmr_load;
  logic [CNT_W-1:0]  w_tmr_load_val;

`ifdef PLAYBACK_ABORT_EN
  assign w_abort = abort && busy_q;
`else
  assign w_abort = 1'b0;
`endif

  assign w_len_ok = (round_len != '0) && (round_len <= N_L);
  assign w_last   = (idx_q == (len_q - 1'b1));

  // Only ticks in ON/OFF advance the timer; an abort wins over a tick.
  assign w_cnt_en       = tick && ((state_q == ST_ON) || (state_q == ST_OFF)) && !w_abort;
  assign w_tmr_clr      = w_abort || (state_q == ST_IDLE);
  assign w_tmr_load     = (state_q == ST_LOAD) || ((state_q == ST_ON) && w_tc);
  assign w_tmr_load_val = (state_q == ST_LOAD) ? CNT_W'(ON_TICKS) : CNT_W'(OFF_TICKS);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (w_tmr_clr),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_load_val),
    .en_i       (w_cnt_en),
    .tc_o       (w_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      code_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      if (w_abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (w_len_ok) begin
                len_q   <= round_len;
                idx_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= ST_FETCH;
              end else begin
                len_err_q <= 1'b1;
              end
            end
          end
          ST_FETCH: state_q <= ST_LOAD;
          ST_LOAD: begin
            // ROM data for idx arrives one cycle after the FETCH address.
            code_q  <= rom_rd_data;
            state_q <= ST_ON;
          end
          ST_ON: begin
            if (w_tc) state_q <= ST_OFF;
          end
          ST_OFF: begin
            if (w_tc) begin
              if (w_last) begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= ST_FETCH;
              end
            end
          end
          ST_DONE: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign rom_rd_addr = busy_q ? idx_q : chk_rd_addr;
  assign led         = (state_q == ST_ON) ? led_decode(code_q) : '0;
  assign busy        = busy_q;
  assign done        = done_q;
  assign len_err     = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_playback_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_playback_controller
//  Description : Self-checking bench for playback_controller. A sequence ROM
//                with one-cycle read latency and a periodic tick source
//                surround the DUT; each playback is judged at step level
//                (LED code order, lit/dark tick counts, done pulses, ROM
//                address ownership) against the stored ROM contents.
//  Build macro : PLAYBACK_ABORT_EN - also exercises the abort input.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_playback_controller;

  localparam int N         = 10;
  localparam int ON_TICKS  = 4;
  localparam int OFF_TICKS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [3:0] round_len = '0;
`ifdef PLAYBACK_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [1:0] rom_rd_data = '0;
  logic [3:0] chk_rd_addr = '0;
  logic [3:0] rom_rd_addr;
  logic [3:0] led;
  logic       busy;
  logic       done;
  logic       len_err;

  logic [1:0] rom [16];
  int         tick_period = 5;
  bit         tick_en = 1'b0;
  int         errors = 0;
  int         checks = 0;

  playback_controller #(
    .N         (N),
    .ON_TICKS  (ON_TICKS),
    .OFF_TICKS (OFF_TICKS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .start       (start),
    .round_len   (round_len),
`ifdef PLAYBACK_ABORT_EN
    .abort       (abort),
`endif
    .rom_rd_data (rom_rd_data),
    .chk_rd_addr (chk_rd_addr),
    .rom_rd_addr (rom_rd_addr),
    .led         (led),
    .busy        (busy),
    .done        (done),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  // Sequence ROM: data valid one clock after the address.
  always @(posedge clk) rom_rd_data <= rom[rom_rd_addr];

  // One-cycle tick strobe every tick_period clocks.
  initial begin : g_tick_src
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      tick = tick_en && (c == 0);
      c = (c + 1 >= tick_period) ? 0 : c + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_led(input logic [1:0] code);
    logic [3:0] one;
    one = 4'b0001;
    return one << code;
  endfunction

  // Start one playback and follow it to completion at step level.
  task automatic run_playback(input int len, input int period, input bit rand_rom,
                              input bit restart);
    int steps = 0, dark = 0, lit = 0, dones = 0, addr_bad = 0, max_addr = 0;
    int lit_bad = 0, dark_bad = 0, cyc = 0, budget;
    bit seen_done = 0, finished = 0;
    logic [3:0] prev_led = '0;
    logic [3:0] obs_led[$];
    if (rand_rom) for (int i = 0; i < 16; i++) rom[i] = 2'($urandom_range(0, 3));
    tick_period = period;
    tick_en = 1'b1;
    budget = len * (ON_TICKS + OFF_TICKS + 3) * period + 40;
    @(posedge clk); #1;
    start = 1'b1;
    round_len = 4'(len);
    @(posedge clk); #1;
    start = 1'b0;
    round_len = 4'($urandom_range(0, 15));
    while (!finished && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (busy) begin
        if (rom_rd_addr >= 4'(len)) addr_bad++;
        if (int'(rom_rd_addr) > max_addr) max_addr = int'(rom_rd_addr);
      end else if (rom_rd_addr !== chk_rd_addr) begin
        addr_bad++;
      end
      if (led != 0 && prev_led == 0) begin
        if (steps > 0 && (dark < OFF_TICKS || dark > OFF_TICKS + 1)) dark_bad++;
        obs_led.push_back(led);
        steps++;
        lit = 0;
      end else if (led != 0 && led != prev_led) begin
        lit_bad++;
      end
      if (led != 0 && tick) lit++;
      if (led == 0 && prev_led != 0) begin
        if (lit != ON_TICKS) lit_bad++;
        dark = 0;
      end
      if (led == 0 && tick) dark++;
      if (done) begin
        dones++;
        seen_done = 1;
      end
      if (seen_done && !busy) finished = 1;
      prev_led = led;
      chk_rd_addr = 4'($urandom_range(0, 15));
      if (restart && cyc == 15) begin
        start = 1'b1;
        round_len = 4'($urandom_range(1, N));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("pb_timeout", 32'(finished), 1);
    check("pb_steps", steps, len);
    for (int i = 0; i < steps && i < len; i++) check("pb_led_code", obs_led[i], exp_led(rom[i]));
    check("pb_lit_ticks_bad", lit_bad, 0);
    check("pb_dark_ticks_bad", dark_bad, 0);
    check("pb_done_pulses", dones, 1);
    check("pb_addr_mux_bad", addr_bad, 0);
    check("pb_max_addr", max_addr, len - 1);
    check("pb_busy_after", 32'(busy), 0);
  endtask

  task automatic try_bad_len(input int len);
    @(posedge clk); #1;
    start = 1'b1;
    round_len = 4'(len);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("lenerr_pulse", 32'(len_err), 1);
    check("lenerr_busy", 32'(busy), 0);
    check("lenerr_led", 32'(led), 0);
    @(negedge clk);
    check("lenerr_clear", 32'(len_err), 0);
    check("lenerr_busy2", 32'(busy), 0);
  endtask

  initial begin : g_main
    int got;
    bit prev_lit;
    for (int i = 0; i < 16; i++) rom[i] = '0;
    chk_rd_addr = 4'd5;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_led", 32'(led), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_lenerr", 32'(len_err), 0);
    check("rst_addr", 32'(rom_rd_addr), 5);
    @(posedge clk); #1;
    reset = 1'b1;

    // Idle address pass-through
    chk_rd_addr = 4'd7;
    @(negedge clk);
    check("idle_addr7", 32'(rom_rd_addr), 7);

    // Directed sequence {2,0,3}, tick every 5 clocks
    rom[0] = 2'd2; rom[1] = 2'd0; rom[2] = 2'd3;
    run_playback(3, 5, 1'b0, 1'b0);

    // Two-step playback: addresses limited to 0,1
    run_playback(2, 4, 1'b1, 1'b0);

    // Illegal lengths
    try_bad_len(0);
    try_bad_len(11);
    try_bad_len(15);

    // Second start during playback is ignored
    run_playback(3, 3, 1'b1, 1'b1);

    // Randomized playbacks
    for (int k = 0; k < 6; k++) begin
      run_playback($urandom_range(1, N), $urandom_range(3, 6), 1'b1, 1'b0);
    end
    run_playback(N, 3, 1'b1, 1'b0);

    // Reset during ON of step 2
    for (int i = 0; i < 16; i++) rom[i] = 2'($urandom_range(0, 3));
    tick_period = 4;
    @(posedge clk); #1;
    start = 1'b1;
    round_len = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    prev_lit = 0;
    for (int c = 0; c < 400 && got < 2; c++) begin
      @(negedge clk);
      if (led != 0 && !prev_lit) got++;
      prev_lit = (led != 0);
    end
    check("rst_mid_reached", got, 2);
    reset = 1'b0;
    #1;
    check("rst_mid_led", 32'(led), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_lenerr", 32'(len_err), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_playback(1, 4, 1'b1, 1'b0);

`ifdef PLAYBACK_ABORT_EN
    // Abort in the OFF gap of step 1
    @(posedge clk); #1;
    start = 1'b1;
    round_len = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    prev_lit = 0;
    for (int c = 0; c < 400 && got == 0; c++) begin
      @(negedge clk);
      if (led == 0 && prev_lit) got = 1;
      prev_lit = (led != 0);
    end
    check("abort_reached_off", got, 1);
    abort = 1'b1;
    chk_rd_addr = 4'd9;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_led", 32'(led), 0);
    check("abort_addr", 32'(rom_rd_addr), 9);
    got = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done || busy) got++;
    end
    check("abort_no_done", got, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
